adv7393_line_serializer: RTL and testbench

//  Parametrised line buffer and serializer for the ADV7393 video path. Accepts AXI-Stream words of packed
//  32-bit pixels, each {Y[31:24], CbCr[23:16], dummy[15:0]}, and drops the dummy byte pair.

---
 rtl/adv7393_line_serializer.sv | 236 +++++++++++++++++++++++
 tb/tb_adv7393_line_serializer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adv7393_line_serializer.sv
// Ring of line buffers feeding the ADV7393 as alternating CbCr/Y bytes.
// Define ADV7393_BIT_REVERSE_EN to bit-reverse every output byte.
module adv7393_line_serializer #(
  parameter int         DWIDTH     = 128,
  parameter int         LINE_LEN   = 640,
  parameter int         NBUF       = 2,
  parameter int         OUT_DWIDTH = 10,
  parameter logic [7:0] BLANK_Y    = 8'h10,
  parameter logic [7:0] BLANK_C    = 8'h80
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DWIDTH-1:0]          s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       s_tlast,
  input  logic                       line_start,
  input  logic                       blank,
  output logic [OUT_DWIDTH-1:0]      out_data,
  output logic                       out_valid,
  output logic [$clog2(NBUF+1)-1:0]  full_cnt,
  output logic                       err_underrun,
  output logic                       err_len,
  output logic                       err_overlap
);

  localparam int PPS = DWIDTH / 32;
  localparam int WPL = LINE_LEN / PPS;
  localparam int IW  = $clog2(NBUF);
  localparam int WW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int LW  = (PPS > 1) ? $clog2(PPS) : 1;
  localparam int AW  = $clog2(NBUF * WPL);
  localparam int MW  = PPS * 16;

  typedef enum logic {
    IDLE,
    LINE
  } rd_state_t;

  function automatic logic [IW-1:0] nxt(
    input logic [IW-1:0] i
  );
    return (i == IW'(NBUF - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [OUT_DWIDTH-1:0] align(
    input logic [7:0] b
  );
    logic [7:0] m;
`ifdef ADV7393_BIT_REVERSE_EN
    for (int i = 0; i < 8; i++) m[i] = b[7-i];
`else
    m = b;
`endif
    return OUT_DWIDTH'(m) << (OUT_DWIDTH - 8);
  endfunction

  logic [NBUF-1:0] full_q;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;
  logic [WW-1:0]   wr_word;
  logic            pad_q;
  logic            acc;
  logic            wr_last;
  logic            wr_done;
  logic            free;
  logic            mem_we;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic [MW-1:0]   mem_wd;
  logic [MW-1:0]   rd_q;
  logic [MW-1:0]   mem [NBUF*WPL];
  logic            unused_bits;

  // dummy halves of each pixel are dropped
  assign unused_bits = ^s_tdata;

  assign s_tready = rst_n && !full_q[wr_idx] && !pad_q;
  assign acc      = s_tvalid && s_tready;
  assign wr_last  = (wr_word == WW'(WPL - 1));
  assign wr_done  = (acc || pad_q) && wr_last;
  assign mem_we   = rst_n && (acc || pad_q);
  assign wr_addr  = AW'(wr_idx) * AW'(WPL) + AW'(wr_word);

  always_comb begin
    mem_wd = '0;
    for (int i = 0; i < PPS; i++) begin
      mem_wd[i*16 +: 16] = pad_q ? {BLANK_Y, BLANK_C}
                                 : s_tdata[i*32+16 +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx  <= '0;
      wr_word <= '0;
      pad_q   <= 1'b0;
      err_len <= 1'b0;
    end else begin
      if (wr_done) begin
        wr_word <= '0;
        pad_q   <= 1'b0;
        wr_idx  <= nxt(wr_idx);
      end else if (acc || pad_q) begin
        wr_word <= wr_word + 1'b1;
        if (acc && s_tlast) pad_q <= 1'b1;
      end
      // tlast must coincide exactly with the last word
      if (acc && (s_tlast != wr_last)) err_len <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= mem_wd;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q   <= '0;
      full_cnt <= '0;
    end else begin
      if (wr_done) full_q[wr_idx] <= 1'b1;
      if (free)    full_q[rd_idx] <= 1'b0;
      unique case ({wr_done, free})
        2'b10:   full_cnt <= full_cnt + 1'b1;
        2'b01:   full_cnt <= full_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  rd_state_t     state_q;
  rd_state_t     state_d;
  logic [WW-1:0] rd_word;
  logic [LW-1:0] rd_lane;
  logic          rd_phase;
  logic          line_blank;
  logic          start;
  logic          line_end;
  logic          have_buf;

  assign have_buf = (full_cnt != '0);
  assign line_end = (state_q == LINE) && rd_phase
                 && (rd_lane == LW'(PPS - 1))
                 && (rd_word == WW'(WPL - 1));
  assign free     = line_end && !line_blank;
  assign rd_addr  = AW'(rd_idx) * AW'(WPL) + AW'(rd_word);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (line_start) begin
          state_d = LINE;
          start   = 1'b1;
        end
      end
      (state_q == LINE): begin
        if (line_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_idx       <= '0;
      rd_word      <= '0;
      rd_lane      <= '0;
      rd_phase     <= 1'b0;
      line_blank   <= 1'b0;
      err_underrun <= 1'b0;
      err_overlap  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        line_blank <= blank || !have_buf;
        if (!blank && !have_buf) err_underrun <= 1'b1;
      end
      if (line_start && (state_q == LINE)) err_overlap <= 1'b1;
      if (state_q == LINE) begin
        rd_phase <= !rd_phase;
        if (rd_phase) begin
          if (rd_lane == LW'(PPS - 1)) begin
            rd_lane <= '0;
            rd_word <= (rd_word == WW'(WPL - 1)) ? '0 : rd_word + 1'b1;
          end else begin
            rd_lane <= rd_lane + 1'b1;
          end
        end
      end
      if (free) rd_idx <= nxt(rd_idx);
    end
  end

  logic          s1_valid;
  logic          s1_phase;
  logic          s1_blank;
  logic [LW-1:0] s1_lane;
  logic [15:0]   s1_px;
  logic [7:0]    s1_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_phase <= 1'b0;
      s1_blank <= 1'b0;
      s1_lane  <= '0;
    end else begin
      s1_valid <= (state_q == LINE);
      s1_phase <= rd_phase;
      s1_blank <= line_blank;
      s1_lane  <= rd_lane;
    end
  end

  always_comb begin
    s1_px = rd_q[16*s1_lane +: 16];
    if (s1_blank) s1_byte = s1_phase ? BLANK_Y : BLANK_C;
    else          s1_byte = s1_phase ? s1_px[15:8] : s1_px[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= s1_valid;
      out_data  <= s1_valid ? align(s1_byte) : '0;
    end
  end

endmodule

// File: tb/tb_adv7393_line_serializer.sv
// Scoreboard bench for adv7393_line_serializer at default parameters.
module tb_adv7393_line_serializer;

  localparam int DWIDTH     = 128;
  localparam int LINE_LEN   = 640;
  localparam int NBUF       = 2;
  localparam int OUT_DWIDTH = 10;
  localparam int PPS        = DWIDTH / 32;
  localparam int WPL        = LINE_LEN / PPS;
  localparam logic [7:0] BY = 8'h10;
  localparam logic [7:0] BC = 8'h80;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [DWIDTH-1:0]     s_tdata = '0;
  logic                  s_tvalid = 1'b0;
  logic                  s_tready;
  logic                  s_tlast = 1'b0;
  logic                  line_start = 1'b0;
  logic                  blank = 1'b0;
  logic [OUT_DWIDTH-1:0] out_data;
  logic                  out_valid;
  logic [1:0]            full_cnt;
  logic                  err_underrun;
  logic                  err_len;
  logic                  err_overlap;

  adv7393_line_serializer #(
    .DWIDTH(DWIDTH), .LINE_LEN(LINE_LEN), .NBUF(NBUF),
    .OUT_DWIDTH(OUT_DWIDTH), .BLANK_Y(BY), .BLANK_C(BC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .s_tlast(s_tlast),
    .line_start(line_start), .blank(blank),
    .out_data(out_data), .out_valid(out_valid),
    .full_cnt(full_cnt), .err_underrun(err_underrun),
    .err_len(err_len), .err_overlap(err_overlap)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [OUT_DWIDTH-1:0] exp_q[$];
  logic [15:0]           mpix[$];
  logic [OUT_DWIDTH-1:0] mon_e;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OUT_DWIDTH-1:0] ex(input logic [7:0] b);
    logic [7:0] m;
`ifdef ADV7393_BIT_REVERSE_EN
    for (int i = 0; i < 8; i++) m[i] = b[7-i];
`else
    m = b;
`endif
    return {m, 2'b00};
  endfunction

  task automatic push_px(input logic [15:0] p);
    exp_q.push_back(ex(p[7:0]));
    exp_q.push_back(ex(p[15:8]));
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_sample", 32'(out_data), 32'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("sample", 32'(out_data), 32'(mon_e));
      end
    end
  end

  task automatic write_line(input int seed, input int last_w);
    logic [15:0] px [LINE_LEN];
    int g;
    for (int n = 0; n < LINE_LEN; n++) begin
      if (n < (last_w + 1) * PPS)
        px[n] = {8'(n + seed), ~8'(n) ^ 8'(seed)};
      else
        px[n] = {BY, BC};
    end
    for (int w = 0; w <= last_w; w++) begin
      for (int i = 0; i < PPS; i++)
        s_tdata[i*32 +: 32] = {px[w*PPS+i], 16'hDEAD};
      s_tvalid = 1'b1;
      s_tlast  = (w == last_w);
      g = 0;
      @(negedge clk);
      while (!s_tready && g < 3000) begin
        @(negedge clk);
        g++;
      end
      if (g >= 3000) begin
        check("wr_ready_timeout", 32'(s_tready), 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    for (int n = 0; n < LINE_LEN; n++) mpix.push_back(px[n]);
  endtask

  task automatic read_line(input logic b);
    @(negedge clk);
    line_start = 1'b1;
    blank      = b;
    if (!b && mpix.size() >= LINE_LEN) begin
      for (int n = 0; n < LINE_LEN; n++) push_px(mpix.pop_front());
    end else begin
      for (int n = 0; n < LINE_LEN; n++) push_px({BY, BC});
    end
    @(posedge clk);
    #1;
    line_start = 1'b0;
    blank      = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 4000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("idle_timeout", 32'(g < 4000), 32'd1);
    if (g >= 4000) exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("tready_in_reset", 32'(s_tready), 32'd0);
    exp_q.delete();
    mpix.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    do_reset();
    check("rst_tready", 32'(s_tready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_full_cnt", 32'(full_cnt), 32'd0);
    check("rst_errs", 32'({err_underrun, err_len, err_overlap}), 32'd0);

    // single line, latency and length
    write_line(0, WPL - 1);
    check("t1_full_cnt", 32'(full_cnt), 32'd1);
    read_line(1'b0);
    check("t1_lat0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_lat1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_lat2", 32'(out_valid), 32'd1);
    nv = 0;
    while (out_valid && nv < 3000) begin
      nv++;
      @(posedge clk); #1;
    end
    check("t1_len", 32'(nv), 32'(2 * LINE_LEN));
    check("t1_full_after", 32'(full_cnt), 32'd0);
    wait_idle();

    // fill every buffer, then one read reopens the write side
    write_line(1, WPL - 1);
    write_line(2, WPL - 1);
    @(negedge clk);
    check("t2_tready_full", 32'(s_tready), 32'd0);
    check("t2_full_cnt", 32'(full_cnt), 32'(NBUF));
    fork
      read_line(1'b0);
      write_line(3, WPL - 1);
    join
    wait_idle();
    check("t2_full_refill", 32'(full_cnt), 32'(NBUF));
    read_line(1'b0);
    wait_idle();
    read_line(1'b0);
    wait_idle();
    check("t2_drained", 32'(full_cnt), 32'd0);

    // underrun and requested blank lines
    check("t3_underrun_pre", 32'(err_underrun), 32'd0);
    read_line(1'b0);
    wait_idle();
    check("t3_underrun", 32'(err_underrun), 32'd1);
    write_line(5, WPL - 1);
    read_line(1'b1);
    wait_idle();
    check("t3_blank_keeps", 32'(full_cnt), 32'd1);
    read_line(1'b0);
    wait_idle();
    check("t3_full_cnt", 32'(full_cnt), 32'd0);

    // short line is padded with blank pixels
    do_reset();
    check("t4_rst_underrun", 32'(err_underrun), 32'd0);
    check("t4_len_pre", 32'(err_len), 32'd0);
    write_line(7, 99);
    repeat (80) @(posedge clk);
    #1;
    check("t4_err_len", 32'(err_len), 32'd1);
    check("t4_full_cnt", 32'(full_cnt), 32'd1);
    check("t4_tready", 32'(s_tready), 32'd1);
    read_line(1'b0);
    wait_idle();
    check("t4_drained", 32'(full_cnt), 32'd0);

    // write completion lands on the same edge as the read free
    write_line(11, WPL - 1);
    read_line(1'b0);
    repeat (2 * LINE_LEN - WPL) @(posedge clk);
    #1;
    write_line(12, WPL - 1);
    check("t5_same_edge_cnt", 32'(full_cnt), 32'd1);
    check("t5_still_out", 32'(out_valid), 32'd1);
    wait_idle();
    check("t5_overlap_pre", 32'(err_overlap), 32'd0);
    read_line(1'b0);
    repeat (200) @(posedge clk);
    @(negedge clk);
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    check("t5_overlap", 32'(err_overlap), 32'd1);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_extra", 32'(out_valid), 32'd0);
    check("t5_drained", 32'(full_cnt), 32'd0);

    // reset in the middle of a line
    write_line(9, WPL - 1);
    read_line(1'b0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_full", 32'(full_cnt), 32'd0);
    check("t6_rst_tready", 32'(s_tready), 32'd0);
    @(negedge clk);
    exp_q.delete();
    mpix.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_tready", 32'(s_tready), 32'd1);
    read_line(1'b1);
    wait_idle();
    write_line(0, WPL - 1);
    read_line(1'b0);
    wait_idle();
    check("t6_full_cnt", 32'(full_cnt), 32'd0);
    check("end_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
